// File: rtl/kf6845_horizontal_mode_loader.sv
// kf6845_horizontal_mode_loader
// Shares the internal data bus and the four horizontal write strobes between
// the CPU register-write path and an automatic 40/80-column mode loader.
// Every output is a register. The combinational block computes what the
// outputs should show in the next cycle, and one register block captures it.
//
// Handshake: cpu_ready is a registered level. A cpu_write pulse is accepted
// only in a cycle where cpu_ready is 1; otherwise the write is dropped.
// Accepted writes either issue a strobe on the next cycle or, while the loader
// owns the bus, park in a one-entry pending buffer. That buffer is drained in
// the FINISH cycle, and cpu_ready stays 0 while the buffer is full.
module kf6845_horizontal_mode_loader #(
    parameter logic [31:0] MODE0_TABLE = 32'h0A_2D_28_38,
    parameter logic [31:0] MODE1_TABLE = 32'h0A_5A_50_71
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       video_clock_enable,
    input  logic       horizontal,
    input  logic       mode_request,
    input  logic       mode_select,
    input  logic       cpu_write,
    input  logic [1:0] cpu_register_select,
    input  logic [7:0] cpu_data,
    output logic       cpu_ready,
    output logic [7:0] internal_data_bus,
    output logic       write_horizontal_total_register,
    output logic       write_horizontal_displayed_register,
    output logic       write_horizontal_sync_position_register,
    output logic       write_horizontal_sync_width_register,
    output logic       busy,
    output logic       load_done,
    output logic       loaded_mode
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LINE = 3'd1,
        ST_WR_TOTAL  = 3'd2,
        ST_WR_DISP   = 3'd3,
        ST_WR_SPOS   = 3'd4,
        ST_WR_SWID   = 3'd5,
        ST_FINISH    = 3'd6
    } state_t;

    // Register select encoding shared by the CPU path and the loader
    localparam logic [1:0] SEL_TOTAL = 2'd0;
    localparam logic [1:0] SEL_DISP  = 2'd1;
    localparam logic [1:0] SEL_SPOS  = 2'd2;
    localparam logic [1:0] SEL_SWID  = 2'd3;

    // State and datapath registers
    state_t     r_state;
    logic       r_mode_latch;
    logic       r_pend_valid;
    logic [1:0] r_pend_sel;
    logic [7:0] r_pend_data;
    logic [7:0] r_bus;
    logic [3:0] r_strobe;      // bit index equals register select
    logic       r_busy;
    logic       r_load_done;
    logic       r_cpu_ready;
    logic       r_loaded_mode;

    // Next-cycle values from the combinational block
    state_t     w_next_state;
    logic       w_latch_mode;
    logic       w_issue;
    logic [1:0] w_issue_sel;
    logic [7:0] w_issue_data;
    logic       w_pend_set;
    logic       w_pend_clear;
    logic       w_next_pend_valid;
    logic       w_next_busy;
    logic       w_next_done;
    logic       w_next_loaded;
    logic       w_cpu_accept;
    logic       w_line_start;

    // Table bytes of the latched mode; only the low nibble of sync width is used
    logic [7:0] w_tbl_total;
    logic [7:0] w_tbl_disp;
    logic [7:0] w_tbl_spos;
    logic [7:0] w_tbl_swid;

    // Select the timing set of the latched mode
    always_comb begin
        if (r_mode_latch) begin
            w_tbl_total = MODE1_TABLE[7:0];
            w_tbl_disp  = MODE1_TABLE[15:8];
            w_tbl_spos  = MODE1_TABLE[23:16];
            w_tbl_swid  = {4'h0, MODE1_TABLE[27:24]};
        end else begin
            w_tbl_total = MODE0_TABLE[7:0];
            w_tbl_disp  = MODE0_TABLE[15:8];
            w_tbl_spos  = MODE0_TABLE[23:16];
            w_tbl_swid  = {4'h0, MODE0_TABLE[27:24]};
        end
    end

    assign w_cpu_accept = cpu_write & r_cpu_ready;
    assign w_line_start = horizontal & video_clock_enable;

    // Next-state logic, bus arbitration and pending-buffer control
    always_comb begin
        w_next_state = r_state;
        w_latch_mode = 1'b0;
        w_issue      = 1'b0;
        w_issue_sel  = SEL_TOTAL;
        w_issue_data = 8'h00;
        w_pend_set   = 1'b0;
        w_pend_clear = 1'b0;
        w_next_busy  = r_busy;
        w_next_done  = 1'b0;
        w_next_loaded = r_loaded_mode;

        case (r_state)
            ST_IDLE: begin
                // A same-cycle CPU write still issues; the loader waits for
                // a line boundary, so there is no bus conflict.
                if (mode_request) begin
                    w_latch_mode = 1'b1;
                    w_next_state = ST_WAIT_LINE;
                    w_next_busy  = 1'b1;
                end
                if (w_cpu_accept) begin
                    w_issue      = 1'b1;
                    w_issue_sel  = cpu_register_select;
                    w_issue_data = cpu_data;
                end
            end

            ST_WAIT_LINE: begin
                // mode_request is ignored here, and there is no timeout.
                w_next_busy = 1'b1;
                if (w_line_start) begin
                    w_next_state = ST_WR_TOTAL;
                    w_issue      = 1'b1;
                    w_issue_sel  = SEL_TOTAL;
                    w_issue_data = w_tbl_total;
                    w_pend_set   = w_cpu_accept;
                end else if (w_cpu_accept) begin
                    w_issue      = 1'b1;
                    w_issue_sel  = cpu_register_select;
                    w_issue_data = cpu_data;
                end
            end

            ST_WR_TOTAL: begin
                w_next_state = ST_WR_DISP;
                w_issue      = 1'b1;
                w_issue_sel  = SEL_DISP;
                w_issue_data = w_tbl_disp;
                w_pend_set   = w_cpu_accept;
            end

            ST_WR_DISP: begin
                w_next_state = ST_WR_SPOS;
                w_issue      = 1'b1;
                w_issue_sel  = SEL_SPOS;
                w_issue_data = w_tbl_spos;
                w_pend_set   = w_cpu_accept;
            end

            ST_WR_SPOS: begin
                w_next_state = ST_WR_SWID;
                w_issue      = 1'b1;
                w_issue_sel  = SEL_SWID;
                w_issue_data = w_tbl_swid;
                w_pend_set   = w_cpu_accept;
            end

            ST_WR_SWID: begin
                // The FINISH cycle shows load_done and drains any parked write.
                // A write accepted now would land in the buffer and drain in
                // the same FINISH cycle, so it goes straight to the bus.
                w_next_state  = ST_FINISH;
                w_next_busy   = 1'b0;
                w_next_done   = 1'b1;
                w_next_loaded = r_mode_latch;
                if (r_pend_valid) begin
                    w_issue      = 1'b1;
                    w_issue_sel  = r_pend_sel;
                    w_issue_data = r_pend_data;
                    w_pend_clear = 1'b1;
                end else if (w_cpu_accept) begin
                    w_issue      = 1'b1;
                    w_issue_sel  = cpu_register_select;
                    w_issue_data = cpu_data;
                end
            end

            ST_FINISH: begin
                // The loader no longer owns the bus; a request here is dropped.
                w_next_state = ST_IDLE;
                if (w_cpu_accept) begin
                    w_issue      = 1'b1;
                    w_issue_sel  = cpu_register_select;
                    w_issue_data = cpu_data;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
                w_next_busy  = 1'b0;
            end
        endcase

        w_next_pend_valid = w_pend_set | (r_pend_valid & ~w_pend_clear);
    end

    // State register and registered outputs; reset aborts any load in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_mode_latch  <= 1'b0;
            r_pend_valid  <= 1'b0;
            r_pend_sel    <= 2'd0;
            r_pend_data   <= 8'h00;
            r_bus         <= 8'h00;
            r_strobe      <= 4'b0000;
            r_busy        <= 1'b0;
            r_load_done   <= 1'b0;
            r_cpu_ready   <= 1'b1;
            r_loaded_mode <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_busy        <= w_next_busy;
            r_load_done   <= w_next_done;
            r_loaded_mode <= w_next_loaded;
            r_pend_valid  <= w_next_pend_valid;
            r_cpu_ready   <= ~w_next_pend_valid;
            if (w_latch_mode) begin
                r_mode_latch <= mode_select;
            end
            if (w_pend_set) begin
                r_pend_sel  <= cpu_register_select;
                r_pend_data <= cpu_data;
            end
            if (w_issue) begin
                r_strobe <= 4'b0001 << w_issue_sel;
                r_bus    <= w_issue_data;
            end else begin
                r_strobe <= 4'b0000;
            end
        end
    end

    assign cpu_ready                               = r_cpu_ready;
    assign internal_data_bus                       = r_bus;
    assign write_horizontal_total_register         = r_strobe[SEL_TOTAL];
    assign write_horizontal_displayed_register     = r_strobe[SEL_DISP];
    assign write_horizontal_sync_position_register = r_strobe[SEL_SPOS];
    assign write_horizontal_sync_width_register    = r_strobe[SEL_SWID];
    assign busy                                    = r_busy;
    assign load_done                               = r_load_done;
    assign loaded_mode                             = r_loaded_mode;

endmodule

// File: tb/tb_kf6845_horizontal_mode_loader.sv
// Testbench for kf6845_horizontal_mode_loader: a table of directed vectors
// followed by hand-written sequences for the line wait and mid-load reset.
module tb_kf6845_horizontal_mode_loader;

    logic       clock;
    logic       reset_n;
    logic       video_clock_enable;
    logic       horizontal;
    logic       mode_request;
    logic       mode_select;
    logic       cpu_write;
    logic [1:0] cpu_register_select;
    logic [7:0] cpu_data;
    logic       cpu_ready;
    logic [7:0] internal_data_bus;
    logic       wr_total;
    logic       wr_disp;
    logic       wr_spos;
    logic       wr_swid;
    logic       busy;
    logic       load_done;
    logic       loaded_mode;

    int checks;
    int failures;

    kf6845_horizontal_mode_loader dut (
        .clock                                   (clock),
        .reset_n                                 (reset_n),
        .video_clock_enable                      (video_clock_enable),
        .horizontal                              (horizontal),
        .mode_request                            (mode_request),
        .mode_select                             (mode_select),
        .cpu_write                               (cpu_write),
        .cpu_register_select                     (cpu_register_select),
        .cpu_data                                (cpu_data),
        .cpu_ready                               (cpu_ready),
        .internal_data_bus                       (internal_data_bus),
        .write_horizontal_total_register         (wr_total),
        .write_horizontal_displayed_register     (wr_disp),
        .write_horizontal_sync_position_register (wr_spos),
        .write_horizontal_sync_width_register    (wr_swid),
        .busy                                    (busy),
        .load_done                               (load_done),
        .loaded_mode                             (loaded_mode)
    );

    // Clock: 10 ns period
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Strobes packed as {total, displayed, sync position, sync width}
    typedef struct {
        logic       wr;
        logic [1:0] sel;
        logic [7:0] data;
        logic       mreq;
        logic       msel;
        logic       hz;
        logic       vce;
        logic [3:0] exp_stb;
        logic [7:0] exp_bus;
        logic       exp_busy;
        logic       exp_done;
        logic       exp_ready;
        logic       exp_lm;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic wr, logic [1:0] sel, logic [7:0] data,
                                logic mreq, logic msel, logic hz, logic vce,
                                logic [3:0] stb, logic [7:0] bus, logic b,
                                logic d, logic r, logic lm);
        vec_t v;
        v.wr = wr; v.sel = sel; v.data = data; v.mreq = mreq; v.msel = msel;
        v.hz = hz; v.vce = vce; v.exp_stb = stb; v.exp_bus = bus;
        v.exp_busy = b; v.exp_done = d; v.exp_ready = r; v.exp_lm = lm;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Outputs settle just after the active edge, so sample #1 later
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [1:0] sel,
                         input logic [7:0] data, input logic mreq,
                         input logic msel, input logic hz, input logic vce);
        cpu_write = wr; cpu_register_select = sel; cpu_data = data;
        mode_request = mreq; mode_select = msel;
        horizontal = hz; video_clock_enable = vce;
    endtask

    function automatic logic [3:0] strobes();
        return {wr_total, wr_disp, wr_spos, wr_swid};
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Stimulus table: inputs held for one cycle, outputs after that edge
        //             wr sel data  mrq msl hz vce  stb      bus   b d r lm
        vecs.push_back(mk(1, 2, 8'h55, 0, 0, 0, 0, 4'b0010, 8'h55, 0, 0, 1, 0)); // CPU write sync position
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 4'b0000, 8'h55, 0, 0, 1, 0)); // bus holds
        vecs.push_back(mk(1, 0, 8'h12, 0, 0, 0, 0, 4'b1000, 8'h12, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 8'h34, 0, 0, 0, 0, 4'b0100, 8'h34, 0, 0, 1, 0));
        vecs.push_back(mk(1, 3, 8'h07, 0, 0, 0, 0, 4'b0001, 8'h07, 0, 0, 1, 0));
        vecs.push_back(mk(1, 2, 8'h66, 1, 1, 0, 0, 4'b0010, 8'h66, 1, 0, 1, 0)); // write + request in IDLE
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 4'b0000, 8'h66, 1, 0, 1, 0)); // request while busy ignored
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 0, 4'b0000, 8'h66, 1, 0, 1, 0)); // horizontal without enable
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 4'b0000, 8'h66, 1, 0, 1, 0)); // enable without horizontal
        vecs.push_back(mk(1, 1, 8'h77, 0, 0, 0, 0, 4'b0100, 8'h77, 1, 0, 1, 0)); // CPU write in WAIT_LINE
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 1, 4'b1000, 8'h71, 1, 0, 1, 0)); // WR_TOTAL mode 1
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 4'b0100, 8'h50, 1, 0, 1, 0)); // WR_DISP, request ignored
        vecs.push_back(mk(1, 0, 8'hAA, 0, 0, 0, 0, 4'b0010, 8'h5A, 1, 0, 0, 0)); // write parked
        vecs.push_back(mk(1, 1, 8'hBB, 0, 0, 0, 0, 4'b0001, 8'h0A, 1, 0, 0, 0)); // write dropped
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 4'b1000, 8'hAA, 0, 1, 1, 1)); // FINISH drains buffer
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 4'b0000, 8'hAA, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 4'b0000, 8'hAA, 1, 0, 1, 1)); // request mode 0
        vecs.push_back(mk(1, 3, 8'h0C, 0, 0, 1, 1, 4'b1000, 8'h38, 1, 0, 0, 1)); // write in exit cycle parked
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 4'b0100, 8'h28, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 4'b0010, 8'h2D, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 4'b0001, 8'h0A, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 4'b0001, 8'h0C, 0, 1, 1, 0)); // FINISH mode 0
        vecs.push_back(mk(1, 0, 8'h99, 0, 0, 0, 0, 4'b1000, 8'h99, 0, 0, 1, 0)); // CPU write in FINISH

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("reset_strobes", {28'd0, strobes()}, 32'd0);
        check("reset_bus", {24'd0, internal_data_bus}, 32'h00);
        check("reset_ready", {31'd0, cpu_ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_loaded", {31'd0, loaded_mode}, 32'd0);
        reset_n = 1'b1;
        tick();
        check("idle_strobes", {28'd0, strobes()}, 32'd0);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].wr, vecs[i].sel, vecs[i].data, vecs[i].mreq,
                  vecs[i].msel, vecs[i].hz, vecs[i].vce);
            tick();
            check($sformatf("v%0d_strobes", i), {28'd0, strobes()}, {28'd0, vecs[i].exp_stb});
            check($sformatf("v%0d_bus", i), {24'd0, internal_data_bus}, {24'd0, vecs[i].exp_bus});
            check($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
            check($sformatf("v%0d_done", i), {31'd0, load_done}, {31'd0, vecs[i].exp_done});
            check($sformatf("v%0d_ready", i), {31'd0, cpu_ready}, {31'd0, vecs[i].exp_ready});
            check($sformatf("v%0d_loaded", i), {31'd0, loaded_mode}, {31'd0, vecs[i].exp_lm});
        end
        drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Long line wait: busy stays high, no strobes until the line boundary
        drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, i[0]);
            tick();
            check($sformatf("wait%0d_busy", i), {31'd0, busy}, 32'd1);
            check($sformatf("wait%0d_strobes", i), {28'd0, strobes()}, 32'd0);
        end
        drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check("wait_total_strobe", {28'd0, strobes()}, 32'b1000);
        check("wait_total_bus", {24'd0, internal_data_bus}, 32'h71);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check("wait_disp_strobe", {28'd0, strobes()}, 32'b0100);
        check("wait_disp_bus", {24'd0, internal_data_bus}, 32'h50);

        // Reset during WR_DISP: strobes drop at once, the load is abandoned
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_strobes", {28'd0, strobes()}, 32'd0);
        check("rst_async_bus", {24'd0, internal_data_bus}, 32'h00);
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("post_rst%0d_strobes", i), {28'd0, strobes()}, 32'd0);
            check($sformatf("post_rst%0d_busy", i), {31'd0, busy}, 32'd0);
            check($sformatf("post_rst%0d_loaded", i), {31'd0, loaded_mode}, 32'd0);
            check($sformatf("post_rst%0d_done", i), {31'd0, load_done}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
